// File: rtl/seg7_display_arbiter_if.sv
// rtl/seg7_display_arbiter_if.sv - request/grant/data bundle between display sources and the arbiter
interface seg7_display_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();
  logic [NUM_REQ-1:0]    req;
  logic [32*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    grant;
  logic [ID_W-1:0]       owner_id;
  logic                  busy;
  logic [31:0]           data_out;

  modport master (
    output req, req_data,
    input  grant, owner_id, busy, data_out
  );

  modport slave (
    input  req, req_data,
    output grant, owner_id, busy, data_out
  );
endinterface

// File: rtl/seg7_display_arbiter.sv
// rtl/seg7_display_arbiter.sv - round-robin owner of the 8-digit display with a minimum hold slice
module seg7_display_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 27
) (
  input  logic                  CLK,
  input  logic                  RST,
  seg7_display_arbiter_if.slave bus
);

  localparam int NSLOT = 1 << ID_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {IDLE, OWN} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic                busy_q, busy_d;
  logic [31:0]         data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  cand;
  logic [NSLOT-1:0]    cand_ext;
  logic [ID_W-1:0]     idx, winner;
  logic                found, owner_req, take;
  logic [31:0]         win_data, own_data;

  // The current owner is masked out so the scan can only hand the display to someone else.
  always_comb begin
    cand     = bus.req & ~((state_q == OWN) ? grant_q : '0);
    cand_ext = NSLOT'(cand);
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((int'(last_q) + off) % NUM_REQ);
      if (!found && cand_ext[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    win_data = '0;
    own_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == winner)  win_data = bus.req_data[32*i +: 32];
      if (ID_W'(i) == owner_q) own_data = bus.req_data[32*i +: 32];
    end
  end

  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        take    = found;
      end
      OWN: begin
        if (!owner_req) begin
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else if (cnt_q != '0) begin
          cnt_d  = cnt_q - 1'b1;
          data_d = own_data;
        end else if (found) begin
          take = 1'b1;
        end else begin
          data_d = own_data;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      state_d = OWN;
      grant_d = NUM_REQ'(1) << winner;
      owner_d = winner;
      last_d  = winner;
      busy_d  = 1'b1;
      data_d  = win_data;
      cnt_d   = CNT_LOAD;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      busy_q  <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner_id = owner_q;
  assign bus.busy     = busy_q;
  assign bus.data_out = data_q;

endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb/tb_seg7_display_arbiter.sv - directed self-checking bench for seg7_display_arbiter
module tb_seg7_display_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int HOLD    = 4;
  localparam int CNT_W   = 3;

  logic        CLK;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] d [4];
  int          n_total;
  int          n_pass;
  int          n_fail;

  seg7_display_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  assign bus.req      = req;
  assign bus.req_data = {d[3], d[2], d[1], d[0]};

  seg7_display_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic [1:0] o,
                           input logic b, input logic [31:0] dat);
    check({tag, ".grant"}, 32'(bus.grant), 32'(g));
    check({tag, ".owner"}, 32'(bus.owner_id), 32'(o));
    check({tag, ".busy"}, 32'(bus.busy), 32'(b));
    check({tag, ".data"}, bus.data_out, dat);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    RST = 1'b1;
    req = 4'b0000;
    d[0] = 32'h0; d[1] = 32'h0; d[2] = 32'h0; d[3] = 32'h0;
    tick();
    tick();
    RST = 1'b0;
    check_all("reset", 4'b0000, 2'd0, 1'b0, 32'h0);

    // 1: single requester, one-cycle grant latency and live data tracking
    req  = 4'b0001;
    d[0] = 32'h12345678;
    tick();
    check_all("t1.grant", 4'b0001, 2'd0, 1'b1, 32'h12345678);
    d[0] = 32'hCAFEBABE;
    tick();
    check("t1.track", bus.data_out, 32'hCAFEBABE);
    req = 4'b0000;
    tick();
    check_all("t1.idle", 4'b0000, 2'd0, 1'b0, 32'hCAFEBABE);

    // 2: two contenders alternate every HOLD cycles
    RST = 1'b1;
    tick();
    RST = 1'b0;
    d[0] = 32'hA0A0A0A0;
    d[1] = 32'hB1B1B1B1;
    d[2] = 32'hC2C2C2C2;
    d[3] = 32'hD3D3D3D3;
    req  = 4'b0011;
    tick();
    check_all("t2.first", 4'b0001, 2'd0, 1'b1, 32'hA0A0A0A0);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check($sformatf("t2.hold0_%0d", i), 32'(bus.grant), 32'h1);
    end
    tick();
    check_all("t2.sw1", 4'b0010, 2'd1, 1'b1, 32'hB1B1B1B1);
    for (int i = 1; i < HOLD; i++) begin
      tick();
      check($sformatf("t2.hold1_%0d", i), 32'(bus.grant), 32'h2);
    end
    tick();
    check_all("t2.sw0", 4'b0001, 2'd0, 1'b1, 32'hA0A0A0A0);

    // 3: owner releases early, direct handoff with no idle gap
    tick();
    req = 4'b0100;
    tick();
    check_all("t3.handoff", 4'b0100, 2'd2, 1'b1, 32'hC2C2C2C2);

    // 4: uncontended owner keeps the display, late request switches immediately
    req = 4'b1000;
    tick();
    check_all("t4.own3", 4'b1000, 2'd3, 1'b1, 32'hD3D3D3D3);
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("t4.hold_%0d", i), 32'(bus.grant), 32'h8);
    end
    d[3] = 32'h33334444;
    tick();
    check("t4.track", bus.data_out, 32'h33334444);
    req = 4'b1010;
    tick();
    check_all("t4.late", 4'b0010, 2'd1, 1'b1, 32'hB1B1B1B1);
    req = 4'b0000;
    tick();
    check_all("t4.drop", 4'b0000, 2'd1, 1'b0, 32'hB1B1B1B1);

    // 5: fairness from last_owner=1 with everyone requesting
    d[3] = 32'hD3D3D3D3;
    req  = 4'b1111;
    tick();
    check_all("t5.g0", 4'b0100, 2'd2, 1'b1, 32'hC2C2C2C2);
    for (int i = 0; i < HOLD; i++) tick();
    check_all("t5.g1", 4'b1000, 2'd3, 1'b1, 32'hD3D3D3D3);
    for (int i = 0; i < HOLD; i++) tick();
    check_all("t5.g2", 4'b0001, 2'd0, 1'b1, 32'hA0A0A0A0);
    for (int i = 0; i < HOLD; i++) tick();
    check_all("t5.g3", 4'b0010, 2'd1, 1'b1, 32'hB1B1B1B1);
    for (int i = 0; i < HOLD; i++) tick();
    check_all("t5.g4", 4'b0100, 2'd2, 1'b1, 32'hC2C2C2C2);

    // 6: reset during ownership, then requester 0 wins first
    RST = 1'b1;
    tick();
    check_all("t6.rst", 4'b0000, 2'd0, 1'b0, 32'h0);
    RST = 1'b0;
    tick();
    check_all("t6.first", 4'b0001, 2'd0, 1'b1, 32'hA0A0A0A0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
